// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt controller for the 5-stage 16-bit pipeline.
// Produces the pipeline-register write enables, IF/ID flush and ID/EX bubble
// controls. It also drains the pipeline after HLT and keeps a saturating
// count of stalled cycles.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ID_Rs,
    input  logic [3:0]       ID_Rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic [3:0]       EX_Rd,
    input  logic             EX_MemRead,
    input  logic             ID_branch_taken,
    input  logic             ID_halt,
    input  logic             mem_stall,
    output logic             pc_wen,
    output logic             if_id_wen,
    output logic             id_ex_wen,
    output logic             ex_mem_wen,
    output logic             mem_wb_wen,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halt_done,
    output logic [CNT_W-1:0] stall_cycles
);

    // Drain counter must be able to hold DRAIN_CYCLES (at least 1 bit wide).
    localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_next_cnt;
    logic             r_halt_done;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_load_use;
    logic             w_stall_evt;

    // A load in EX whose destination feeds a used ID operand (R0 never counts).
    assign w_load_use = EX_MemRead & (EX_Rd != 4'd0) &
                        ((ID_uses_rs & (ID_Rs == EX_Rd)) |
                         (ID_uses_rt & (ID_Rt == EX_Rd)));

    // A stalled cycle is a frozen or load-use cycle in RUN, or a frozen DRAIN cycle.
    assign w_stall_evt = ((r_state == S_RUN) & (mem_stall | w_load_use)) |
                         ((r_state == S_DRAIN) & mem_stall);

    // State register, drain counter, halt flag and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_RUN;
            r_cnt          <= {CW{1'b0}};
            r_halt_done    <= 1'b0;
            r_stall_cycles <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_halt_done <= (w_next_state == S_HALTED);
            if (w_stall_evt && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
        end
    end

    // Next-state logic: HLT only counts as accepted when nothing outranks it.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (!mem_stall && !w_load_use && ID_halt) begin
                    w_next_state = S_DRAIN;
                    w_next_cnt   = CW'(DRAIN_CYCLES);
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DRAIN: begin
                if (mem_stall) begin
                    w_next_state = S_DRAIN;
                end else if (r_cnt == {CW{1'b0}}) begin
                    w_next_state = S_HALTED;
                end else begin
                    w_next_cnt = r_cnt - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            default: begin
                w_next_state = S_RUN;
                w_next_cnt   = {CW{1'b0}};
            end
        endcase
    end

    // Output decode: enables, flush and bubble, with zero latency from hazards.
    always_comb begin
        pc_wen       = 1'b0;
        if_id_wen    = 1'b0;
        id_ex_wen    = 1'b0;
        ex_mem_wen   = 1'b0;
        mem_wb_wen   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (rst) begin
            pc_wen = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (mem_stall) begin
                        pc_wen = 1'b0;
                    end else if (w_load_use) begin
                        id_ex_wen    = 1'b1;
                        id_ex_bubble = 1'b1;
                        ex_mem_wen   = 1'b1;
                        mem_wb_wen   = 1'b1;
                    end else if (ID_halt) begin
                        id_ex_wen  = 1'b1;
                        ex_mem_wen = 1'b1;
                        mem_wb_wen = 1'b1;
                    end else if (ID_branch_taken) begin
                        pc_wen      = 1'b1;
                        if_id_wen   = 1'b1;
                        id_ex_wen   = 1'b1;
                        ex_mem_wen  = 1'b1;
                        mem_wb_wen  = 1'b1;
                        if_id_flush = 1'b1;
                    end else begin
                        pc_wen     = 1'b1;
                        if_id_wen  = 1'b1;
                        id_ex_wen  = 1'b1;
                        ex_mem_wen = 1'b1;
                        mem_wb_wen = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (mem_stall) begin
                        pc_wen = 1'b0;
                    end else begin
                        id_ex_wen    = 1'b1;
                        id_ex_bubble = 1'b1;
                        ex_mem_wen   = 1'b1;
                        mem_wb_wen   = 1'b1;
                    end
                end
                S_HALTED: begin
                    pc_wen = 1'b0;
                end
                default: begin
                    pc_wen = 1'b0;
                end
            endcase
        end
    end

    assign halt_done    = r_halt_done & ~rst;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl with hand-computed expectations.
// Built with CNT_W = 4 so that counter saturation is reachable quickly.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] ID_Rs;
    logic [3:0] ID_Rt;
    logic       ID_uses_rs;
    logic       ID_uses_rt;
    logic [3:0] EX_Rd;
    logic       EX_MemRead;
    logic       ID_branch_taken;
    logic       ID_halt;
    logic       mem_stall;
    logic       pc_wen;
    logic       if_id_wen;
    logic       id_ex_wen;
    logic       ex_mem_wen;
    logic       mem_wb_wen;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       halt_done;
    logic [3:0] stall_cycles;

    int checks;
    int errors;

    pipeline_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
        .ID_branch_taken(ID_branch_taken), .ID_halt(ID_halt),
        .mem_stall(mem_stall),
        .pc_wen(pc_wen), .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen),
        .ex_mem_wen(ex_mem_wen), .mem_wb_wen(mem_wb_wen),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .halt_done(halt_done), .stall_cycles(stall_cycles)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Enables packed as {pc, if_id, id_ex, ex_mem, mem_wb}.
    task automatic check_outs(input string tag, input logic [4:0] wen,
                              input logic flush, input logic bubble, input logic hd);
        check({tag, ".wen"}, 32'({pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen}), 32'(wen));
        check({tag, ".flush"}, 32'(if_id_flush), 32'(flush));
        check({tag, ".bubble"}, 32'(id_ex_bubble), 32'(bubble));
        check({tag, ".halt_done"}, 32'(halt_done), 32'(hd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ID_Rs = 4'd0; ID_Rt = 4'd0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
        EX_Rd = 4'd0; EX_MemRead = 1'b0; ID_branch_taken = 1'b0;
        ID_halt = 1'b0; mem_stall = 1'b0;
    endtask

    task automatic set_load_use();
        EX_MemRead = 1'b1; EX_Rd = 4'd5; ID_Rs = 4'd5; ID_uses_rs = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr();
        rst = 1'b1;
        #1;
        check_outs("rst_forced", 5'b00000, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_stall_cnt", 32'(stall_cycles), 32'd0);
        check_outs("run_idle", 5'b11111, 1'b0, 1'b0, 1'b0);

        // Load-use: one stall cycle, counter 0 -> 1, then normal.
        set_load_use();
        #1;
        check_outs("load_use", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        check("load_use_cnt", 32'(stall_cycles), 32'd1);
        EX_MemRead = 1'b0;
        #1;
        check_outs("after_load_use", 5'b11111, 1'b0, 1'b0, 1'b0);
        tick();

        // R0 destination and unused operand never stall.
        clr();
        EX_MemRead = 1'b1; EX_Rd = 4'd0; ID_Rs = 4'd0; ID_uses_rs = 1'b1;
        #1;
        check_outs("r0_no_stall", 5'b11111, 1'b0, 1'b0, 1'b0);
        clr();
        EX_MemRead = 1'b1; EX_Rd = 4'd3; ID_Rt = 4'd3; ID_uses_rt = 1'b0;
        #1;
        check_outs("unused_rt", 5'b11111, 1'b0, 1'b0, 1'b0);
        ID_uses_rt = 1'b1;
        #1;
        check_outs("used_rt_stall", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        check("rt_stall_cnt", 32'(stall_cycles), 32'd2);

        // Branch alone flushes; branch under load-use only stalls.
        clr();
        ID_branch_taken = 1'b1;
        #1;
        check_outs("branch", 5'b11111, 1'b1, 1'b0, 1'b0);
        tick();
        set_load_use();
        #1;
        check_outs("branch_vs_lu", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        check("branch_lu_cnt", 32'(stall_cycles), 32'd3);

        // mem_stall freezes everything for 3 cycles, counter +3.
        clr();
        set_load_use();
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_outs("mem_freeze", 5'b00000, 1'b0, 1'b0, 1'b0);
            tick();
        end
        check("freeze_cnt", 32'(stall_cycles), 32'd6);
        mem_stall = 1'b0;
        #1;
        check_outs("post_freeze_lu", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        check("post_freeze_cnt", 32'(stall_cycles), 32'd7);

        // HLT together with branch: DRAIN entered, no flush, halted at t+4.
        clr();
        ID_halt = 1'b1; ID_branch_taken = 1'b1;
        #1;
        check_outs("halt_t", 5'b00111, 1'b0, 1'b0, 1'b0);
        tick();
        clr();
        for (int i = 1; i <= 3; i++) begin
            #1;
            check_outs("drain", 5'b00111, 1'b0, 1'b1, 1'b0);
            tick();
        end
        #1;
        check_outs("halted_t4", 5'b00000, 1'b0, 1'b0, 1'b1);
        mem_stall = 1'b1;
        tick();
        tick();
        check_outs("halted_hold", 5'b00000, 1'b0, 1'b0, 1'b1);
        check("halted_no_count", 32'(stall_cycles), 32'd7);

        // Reset out of HALTED, then HLT with a mem_stall at t+2.
        clr();
        rst = 1'b1;
        #1;
        check_outs("rst_in_halted", 5'b00000, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("rst2_cnt", 32'(stall_cycles), 32'd0);
        ID_halt = 1'b1;
        #1;
        check_outs("halt2_t", 5'b00111, 1'b0, 1'b0, 1'b0);
        tick();
        clr();
        #1;
        check_outs("halt2_t1", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        mem_stall = 1'b1;
        #1;
        check_outs("halt2_t2_frz", 5'b00000, 1'b0, 1'b0, 1'b0);
        tick();
        mem_stall = 1'b0;
        check("drain_stall_cnt", 32'(stall_cycles), 32'd1);
        #1;
        check_outs("halt2_t3", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        check_outs("halt2_t4", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        check_outs("halt2_t5", 5'b00000, 1'b0, 1'b0, 1'b1);

        // Reset mid-DRAIN returns to RUN with cleared state.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ID_halt = 1'b1;
        tick();
        clr();
        #1;
        check_outs("mid_drain", 5'b00111, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check_outs("rst_in_drain", 5'b00000, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_outs("run_after_rst", 5'b11111, 1'b0, 1'b0, 1'b0);
        check("rst3_cnt", 32'(stall_cycles), 32'd0);

        // Saturation: 20 frozen cycles on a 4-bit counter stop at 15.
        mem_stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("saturate", 32'(stall_cycles), 32'd15);
        mem_stall = 1'b0;
        #1;
        check_outs("after_sat", 5'b11111, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
